// File: rtl/adder_64b_pkg.sv
// Shared constants and carry-lookahead helpers for the 64-bit adder/subtractor.
package adder_64b_pkg;

  localparam int unsigned XLEN = 64;

  // ALU op encoding for the add/sub select.
  localparam logic AluOpAdd = 1'b0;
  localparam logic AluOpSub = 1'b1;

  // Lookahead carries into positions 1..3 of a 4-wide g/p group, given carry-in c.
  function automatic logic [2:0] la_carries(input logic [3:0] g, input logic [3:0] p,
                                            input logic c);
    logic [2:0] cy;
    cy[0] = g[0] | (p[0] & c);
    cy[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cy[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    return cy;
  endfunction

  // Group generate of a 4-wide g/p group.
  function automatic logic la_group_g(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/adder_64b_cla16.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
// Exposes block generate/propagate for a higher lookahead level.
module adder_64b_cla16
  import adder_64b_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] s,
  output logic        g,
  output logic        p
);

  logic [15:0] bit_g, bit_p, bit_c;
  logic [3:0]  grp_g, grp_p, grp_c;

  always_comb begin
    bit_g = a & b;
    bit_p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      grp_g[k] = la_group_g(bit_g[4*k +: 4], bit_p[4*k +: 4]);
      grp_p[k] = &bit_p[4*k +: 4];
    end
    grp_c = {la_carries(grp_g, grp_p, c_in), c_in};
    for (int k = 0; k < 4; k++) begin
      bit_c[4*k +: 4] = {la_carries(bit_g[4*k +: 4], bit_p[4*k +: 4], grp_c[k]), grp_c[k]};
    end
    s = bit_p ^ bit_c;
    g = la_group_g(grp_g, grp_p);
    p = &grp_p;
  end

endmodule

// File: rtl/adder_64b.sv
// Registered 64-bit add/subtract: {c_o, s} = a + (sub ? ~b : b) + sub, one cycle latency.
module adder_64b
  import adder_64b_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sub,
  output logic [XLEN-1:0] s,
  output logic            c_o
);

  logic [XLEN-1:0] b_eff, sum_d, s_q;
  logic            c_in, c_d, c_q;
  logic [3:0]      blk_g, blk_p, blk_c;

  assign b_eff = (sub == AluOpAdd) ? b : ~b;
  assign c_in  = (sub == AluOpSub);

  for (genvar i = 0; i < 4; i++) begin : g_blk
    adder_64b_cla16 u_cla16 (
      .a    (a[16*i +: 16]),
      .b    (b_eff[16*i +: 16]),
      .c_in (blk_c[i]),
      .s    (sum_d[16*i +: 16]),
      .g    (blk_g[i]),
      .p    (blk_p[i])
    );
  end

  // Second-level lookahead across the four 16-bit blocks.
  always_comb begin
    blk_c = {la_carries(blk_g, blk_p, c_in), c_in};
    c_d   = la_group_g(blk_g, blk_p) | (&blk_p & c_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else begin
      s_q <= sum_d;
      c_q <= c_d;
    end
  end

  assign s   = s_q;
  assign c_o = c_q;

endmodule

// File: tb/tb_adder_64b.sv
// Scoreboard bench for adder_64b: driver queues expected {c_o, s}, monitor checks each edge.
module tb_adder_64b;

  typedef struct {
    logic [64:0] exp;
    string       name;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        sub = 1'b0;
  logic [63:0] s;
  logic        c_o;

  int n_checks = 0;
  int n_fail = 0;
  sb_entry_t exp_q[$];

  adder_64b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .s     (s),
    .c_o   (c_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got c_o=%0b s=%h, expected c_o=%0b s=%h",
               name, act[64], act[63:0], exp[64], exp[63:0]);
    end
  endtask

  // Drive one operation on the falling edge; its result is due after the next rising edge.
  task automatic issue(input string name, input logic [63:0] ai, input logic [63:0] bi,
                       input logic si, input logic [64:0] exp);
    sb_entry_t e;
    @(negedge clk);
    a = ai;
    b = bi;
    sub = si;
    e.exp = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  function automatic logic [64:0] ref_sum(input logic [63:0] ai, input logic [63:0] bi,
                                          input logic si);
    logic [64:0] be;
    be = {1'b0, (si ? ~bi : bi)};
    return {1'b0, ai} + be + {64'd0, si};
  endfunction

  // Monitor: the DUT presents a result every cycle out of reset.
  always @(posedge clk) begin
    sb_entry_t e;
    #1;
    if (rst_n && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(e.name, {c_o, s}, e.exp);
    end
  end

  // Async reset mid-stream: drive a new op, then pull reset before it is captured.
  task automatic mid_reset();
    @(negedge clk);
    a = 64'hDEAD_BEEF_0123_4567;
    b = 64'hFFFF_0000_FFFF_0000;
    sub = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_immediate", {c_o, s}, 65'd0);
    exp_q.delete();
    @(posedge clk);
    #2;
    check("mid_reset_held", {c_o, s}, 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rs;

    a = '1;
    b = '1;
    sub = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_hold", {c_o, s}, 65'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("reset_release", '1, '1, 1'b0, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
    issue("add_wrap", '1, 64'd1, 1'b0, {1'b1, 64'h0});
    issue("sub_10_3", 64'd10, 64'd3, 1'b1, {1'b1, 64'd7});
    issue("sub_equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
          {1'b1, 64'h0});
    issue("sub_3_10", 64'd3, 64'd10, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFF9});
    issue("sub_0_1", 64'd0, 64'd1, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    issue("grp_bit3", 64'h0000_0000_0000_000F, 64'd1, 1'b0, {1'b0, 64'h0000_0000_0000_0010});
    issue("blk_bit15", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, {1'b0, 64'h0000_0000_0001_0000});
    issue("blk_bit31", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, {1'b0, 64'h0000_0001_0000_0000});
    issue("blk_bit47", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, {1'b0, 64'h0001_0000_0000_0000});
    issue("same_ops_add", 64'd5, 64'd3, 1'b0, {1'b0, 64'd8});
    issue("same_ops_sub", 64'd5, 64'd3, 1'b1, {1'b1, 64'd2});
    issue("mixed_add", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0,
          {1'b1, 64'h0000_0000_0000_0001});

    for (int i = 0; i < 1000; i++) begin
      if (i == 500) mid_reset();
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rs = 1'($urandom_range(1, 0));
      issue("random", ra, rb, rs, ref_sum(ra, rb, rs));
    end

    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_64b.md
# adder_64b

Registered 64-bit two's-complement adder/subtractor for the RV64F datapath. Computes a + b or a − b (as a + ~b + 1) with carry-out, using a carry-lookahead structure. Result and carry are captured on the rising clock edge, so downstream logic sees registered values.

## Interface
- No parameters; width fixed at 64.
- One clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  64  operand A
- b  input  64  operand B
- sub  input  1  0: a + b; 1: a − b
- s  output  64  registered 64-bit result
- c_o  output  1  registered carry-out (bit 64 of the 65-bit sum)

## Operation
- Effective B: b_eff = sub ? ~b : b. Carry-in: c_in = sub.
- 65-bit sum: {c_o, s} = a + b_eff + c_in, computed unsigned.
- Subtraction carry-out: c_o = 1 when a ≥ b unsigned (no borrow); c_o = 0 when a < b.
- No overflow flag and no saturation; wrap-around modulo 2^64.
- The carry chain is carry-lookahead: 4-bit generate/propagate groups, 16-bit blocks, top-level lookahead across four 16-bit blocks. No ripple across more than 4 bits.
- Purely data-driven; no handshake, no enable. A new operation is accepted every cycle.

## Timing
- Latency: 1 cycle. Inputs sampled at rising edge N appear on s/c_o after edge N.
- Throughput: one result per cycle.
- Reset: when rst_n goes low, s = 64'h0 and c_o = 0 immediately, independent of clk. Held while rst_n is low.
- First valid result: available after the first rising edge following rst_n deassertion.
- Reset asserted mid-stream: the in-flight result is discarded, and outputs go to 0 at once.
- Changing sub with the same operands between cycles: each cycle's result reflects that cycle's sub.
- Combinational path a/b/sub → register D must close at the project target clock. No output combinational path from inputs.

## Structure
- Sub-module cla16: 16-bit carry-lookahead adder.
  - Ports: a[15:0], b[15:0], c_in → s[15:0], group generate G, group propagate P.
  - Internally built from four 4-bit lookahead groups.
- Top level contains:
  - b inversion.
  - Four cla16 instances.
  - Second-level lookahead unit producing block carries and c_o.
  - Output register.
- Shared package (riscv_pkg or equivalent) holds:
  - XLEN = 64 constant.
  - ALU op encoding if sub is later derived from an opcode.
- No typedefs required.

## Test plan
- Reset: hold rst_n = 0 with a = b = all ones, sub = 0 → s = 0, c_o = 0. Release rst_n and clock → s = 64'hFFFF_FFFF_FFFF_FFFE, c_o = 1.
- Add wrap: a = 64'hFFFF_FFFF_FFFF_FFFF, b = 1, sub = 0 → s = 0, c_o = 1. Full carry propagation across all blocks.
- Subtract no borrow: a = 10, b = 3, sub = 1 → s = 7, c_o = 1. Also a = b = 64'h1234_5678_9ABC_DEF0 → s = 0, c_o = 1.
- Subtract with borrow: a = 3, b = 10, sub = 1 → s = 64'hFFFF_FFFF_FFFF_FFF9, c_o = 0. Also a = 0, b = 1 → s = all ones, c_o = 0.
- Block boundaries: a = 64'h0000_0000_0000_FFFF, b = 1, sub = 0 → s = 64'h0000_0000_0001_0000, c_o = 0. Repeat for bits 31 and 47.
- Random: 1000 back-to-back cycles with random 64-bit a, b and random sub. Compare against the 65-bit reference {c_o, s} = a + (sub ? ~b : b) + sub, delayed one cycle. Zero mismatches required, with a reset asserted mid-run.
